// File: rtl/coin_pkg.sv
// Coin codes and values shared by the coin acceptor and the vending FSM.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_05   = 2'b01,
    COIN_10   = 2'b10
  } coin_code_e;

  // Coin values in 0.5-yuan units
  localparam int unsigned VAL_05 = 1;
  localparam int unsigned VAL_10 = 2;

  function automatic int unsigned coin_val(input coin_code_e c);
    case (c)
      COIN_05: coin_val = VAL_05;
      COIN_10: coin_val = VAL_10;
      default: coin_val = 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor: 2-flop synchroniser, stability counter, registered rising-edge event.
module coin_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic sensor_i,
  output logic evt_o
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the edge the count would reach DEB_CYCLES; any agreeing
  // cycle (including bounce back) restarts the count from zero.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    evt_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
        evt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced sensors -> pending flags -> one coin code per cycle.
// Optional saturating accepted-value counter on total_05 when COIN_TOTAL_EN is defined.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned TOT_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sensor_05,
  input  logic             sensor_10,
  input  logic             accept_en,
  output logic [1:0]       coin,
`ifdef COIN_TOTAL_EN
  output logic [TOT_W-1:0] total_05,
`endif
  output logic             reject
);

  logic [1:0] sensor;
  logic [1:0] evt;

  assign sensor = {sensor_10, sensor_05};

  for (genvar i = 0; i < 2; i++) begin : g_deb
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rstn     (rstn),
      .sensor_i (sensor[i]),
      .evt_o    (evt[i])
    );
  end

  logic       pend_05_q, pend_05_d;
  logic       pend_10_q, pend_10_d;
  logic       reject_q, reject_d;
  coin_code_e coin_q, coin_d;

  // Clear-then-set ordering: an event landing on the cycle its flag drains re-arms it.
  always_comb begin
    coin_d    = COIN_NONE;
    pend_05_d = pend_05_q;
    pend_10_d = pend_10_q;
    if (pend_05_q) begin
      coin_d    = COIN_05;
      pend_05_d = 1'b0;
    end else if (pend_10_q) begin
      coin_d    = COIN_10;
      pend_10_d = 1'b0;
    end
    if (accept_en) begin
      if (evt[0]) pend_05_d = 1'b1;
      if (evt[1]) pend_10_d = 1'b1;
    end
    reject_d = (|evt) & ~accept_en;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_05_q <= 1'b0;
      pend_10_q <= 1'b0;
      reject_q  <= 1'b0;
      coin_q    <= COIN_NONE;
    end else begin
      pend_05_q <= pend_05_d;
      pend_10_q <= pend_10_d;
      reject_q  <= reject_d;
      coin_q    <= coin_d;
    end
  end

  assign coin   = coin_q;
  assign reject = reject_q;

`ifdef COIN_TOTAL_EN
  logic [TOT_W-1:0] total_q, total_d;
  logic [TOT_W:0]   sum;

  // Accumulate with the code being registered so total tracks coin on the same edge.
  always_comb begin
    sum     = {1'b0, total_q} + (TOT_W + 1)'(coin_val(coin_d));
    total_d = sum[TOT_W] ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) total_q <= '0;
    else       total_q <= total_d;
  end

  assign total_05 = total_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized + directed bench for coin_acceptor against a behavioural model.
module tb_coin_acceptor;
  localparam int DEB  = 4;
  localparam int TW   = 3;
  localparam int TMAX = (1 << TW) - 1;

  logic       clk = 1'b0, rstn = 1'b0;
  logic       s05 = 1'b0, s10 = 1'b0, acc = 1'b1;
  logic [1:0] coin;
  logic       reject;
`ifdef COIN_TOTAL_EN
  logic [TW-1:0] total;
`endif

  always #5 clk = ~clk;

  coin_acceptor #(.DEB_CYCLES(DEB), .TOT_W(TW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sensor_05 (s05),
    .sensor_10 (s10),
    .accept_en (acc),
    .coin      (coin),
`ifdef COIN_TOTAL_EN
    .total_05  (total),
`endif
    .reject    (reject)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: sensor level seen by the debouncer lags the pin by two samples; a level
  // is accepted after DEB consecutive disagreeing samples; accepted coins queue as
  // one flag per denomination, drained 0.5 first.
  bit ha[2], hb[2], deb[2], evt[2], pnd[2];
  int run[2];
  int e_coin, e_rej, e_tot;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ha[i] = 0; hb[i] = 0; deb[i] = 0; evt[i] = 0; pnd[i] = 0; run[i] = 0;
    end
    e_coin = 0; e_rej = 0; e_tot = 0;
  endtask

  task automatic model_step();
    bit raw[2];
    bit seen;
    raw[0] = s05; raw[1] = s10;
    e_coin = 0;
    if (pnd[0]) begin e_coin = 1; pnd[0] = 0; end
    else if (pnd[1]) begin e_coin = 2; pnd[1] = 0; end
    e_tot = e_tot + e_coin;
    if (e_tot > TMAX) e_tot = TMAX;
    e_rej = ((evt[0] || evt[1]) && !acc) ? 1 : 0;
    if (acc) begin
      if (evt[0]) pnd[0] = 1;
      if (evt[1]) pnd[1] = 1;
    end
    for (int i = 0; i < 2; i++) begin
      seen = hb[i]; hb[i] = ha[i]; ha[i] = raw[i];
      evt[i] = 0;
      if (seen != deb[i]) begin
        run[i]++;
        if (run[i] == DEB) begin
          deb[i] = seen; run[i] = 0; evt[i] = seen;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  int edge_n, f05, f10, frej, c05, c10, crej;

  task automatic mark();
    edge_n = 0; f05 = -1; f10 = -1; frej = -1; c05 = 0; c10 = 0; crej = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) model_step(); else model_reset();
    edge_n++;
    @(negedge clk);
    chk("coin", coin, e_coin);
    chk("reject", reject, e_rej);
`ifdef COIN_TOTAL_EN
    chk("total", total, e_tot);
`endif
    if (coin == 2'b01) begin c05++; if (f05 < 0) f05 = edge_n - 1; end
    if (coin == 2'b10) begin c10++; if (f10 < 0) f10 = edge_n - 1; end
    if (reject) begin crej++; if (frej < 0) frej = edge_n - 1; end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    mark();
    @(negedge clk);
    tick();
    chk("rst_coin", coin, 0);
    chk("rst_reject", reject, 0);
    rstn = 1'b1;
    repeat (3) tick();

    // isolated 0.5 coin
    s05 = 1'b1; mark();
    repeat (20) tick();
    s05 = 1'b0;
    repeat (10) tick();
    chk("t1_edge", f05, 7);
    chk("t1_count", c05, 1);
    chk("t1_reject", crej, 0);

    // short glitch
    s10 = 1'b1; mark();
    repeat (3) tick();
    s10 = 1'b0;
    repeat (12) tick();
    chk("t2_coins", c05 + c10, 0);

    // simultaneous coins
    s05 = 1'b1; s10 = 1'b1; mark();
    repeat (12) tick();
    s05 = 1'b0; s10 = 1'b0;
    repeat (10) tick();
    chk("t3_edge05", f05, 7);
    chk("t3_edge10", f10, 8);
    chk("t3_count", c05 + c10, 2);

    // rejected coin
    acc = 1'b0; s10 = 1'b1; mark();
    repeat (10) tick();
    s10 = 1'b0;
    repeat (10) tick();
    chk("t4_rej_edge", frej, 6);
    chk("t4_rej_count", crej, 1);
    chk("t4_coins", c10, 0);
    acc = 1'b1;

    // reset during debounce, sensor held high
    s05 = 1'b1; mark();
    repeat (3) tick();
    do_reset();
    c05 = 0;
    repeat (DEB + 2) tick();
    chk("t5_quiet", c05, 0);
    repeat (6) tick();
    s05 = 1'b0;
    repeat (10) tick();

    // four 1-yuan coins from a clean total
    do_reset(); mark();
    for (int k = 0; k < 4; k++) begin
      s10 = 1'b1; repeat (8) tick();
      s10 = 1'b0; repeat (8) tick();
    end
    chk("t6_count", c10, 4);
`ifdef COIN_TOTAL_EN
    chk("t6_total", total, 7);
`endif

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(5) == 0) s05 = ~s05;
      if ($urandom_range(5) == 0) s10 = ~s10;
      if ($urandom_range(24) == 0) acc = ~acc;
      if ($urandom_range(600) == 0) do_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
